fp_mem_sequencer: RTL
=====================

Name: fp_mem_sequencer

Overview:
- Load/store sequencer sitting between the FP pipeline's memory stage and the 32-bit data memory port. It drives the write and read sides of the FP register file (FPWriteRegister/FPWriteData/FPRegWrite/fmt, FPReadRegister1/FPReadData1).
- Executes LWC1/SWC1 (fmt 5'h10) as one word access and LDC1/SDC1 (fmt 5'h11) as two word accesses. Data is moved to or from an even/odd register pair: low word in reg, high word in reg+1.

Parameters:
- MEM_TIMEOUT, 255, max cycles to wait for mem_ack per access; 0 disables the timeout.
- TO_W, 8, timeout counter width.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle, request accepted when valid&ready.
- req_store  in  1  1 = store (register to memory), 0 = load.
- req_fmt  in  5  5'h10 single, 5'h11 double.
- req_fpreg  in  5  FP register number.
- req_addr  in  32  byte address.
- mem_req  out  1  memory access strobe, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address (byte units).
- mem_wdata  out  32  store data.
- mem_ack  in  1  access complete this cycle.
- mem_rdata  in  32  load data, valid with mem_ack.
- fp_fmt  out  5  to register file fmt.
- fp_rd_reg  out  5  to FPReadRegister1.
- fp_rd_data  in  64  from FPReadData1.
- fp_we  out  1  to FPRegWrite.
- fp_wr_reg  out  5  to FPWriteRegister.
- fp_wr_data  out  64  to FPWriteData.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; request failed.

Behaviour:
- Reset (async, immediate): state IDLE; every output 0 except req_ready=1. Internal 64-bit buffer, captured request and timeout counter cleared. Reset mid-access drops mem_req and fp_we at once. No partial register write is completed.
- States: IDLE, RDREG, MEM_LO, MEM_HI, WRREG, DONE.
- IDLE: req_ready=1. On valid&ready, capture all req_* fields and check legality:
  - illegal = fmt not in {10,11}, OR double with odd req_fpreg, OR single with addr[1:0]!=0, OR double with addr[2:0]!=0.
  - Illegal -> DONE with err=1; no memory or register activity.
  - Legal store -> RDREG. Legal load -> MEM_LO.
- RDREG (one cycle): fp_rd_reg=reg and fp_fmt=fmt are driven from cycle entry. The register file samples on negedge. At the next posedge, buffer <= fp_rd_data. -> MEM_LO.
- MEM_LO: mem_req=1, mem_addr=addr, mem_we=store, mem_wdata=buf[31:0].
  - On mem_ack: if load, buf[31:0] <= mem_rdata. Then double -> MEM_HI; single load -> WRREG; single store -> DONE.
- MEM_HI: mem_req=1, mem_addr=addr+4, mem_wdata=buf[63:32].
  - On mem_ack: if load, buf[63:32] <= mem_rdata. Then load -> WRREG, store -> DONE.
- Timeout: counter cleared on entering MEM_LO/MEM_HI and incremented each cycle without ack. When it reaches MEM_TIMEOUT (nonzero) before ack: mem_req drops, -> DONE with err=1, and no fp_we is issued.
  - An ack arriving in the same cycle the limit is reached wins.
- WRREG (one cycle): fp_we=1, fp_wr_reg=reg, fp_fmt=fmt, fp_wr_data=buf. Single format forces the upper 32 bits to 0. -> DONE.
- DONE (one cycle): done=1, err per outcome. -> IDLE; req_ready is 0 during DONE.
- fp_fmt holds the captured fmt from accept until DONE, and is 0 in IDLE.
- mem_addr wraps mod 2^32 on +4.
- Register 0 is not special-cased; the register file discards writes to it.
- Latency with same-cycle ack, counted from the accept edge (done asserted in cycle N):
  - single load 3, double load 4;
  - single store 3, double store 4;
  - illegal 1.

Decomposition:
- Shared package fp_pkg: FMT_S=5'h10, FMT_D=5'h11, state enum, and legality-check function (shared with the FP decode stage).
- No sub-module; the timeout counter stays inline.

Test Plan:
- Double load, reg 4, addr 0x100; memory returns 0x00000000@0x100 and 0x3FF00000@0x104 with immediate ack -> mem_addr 0x100 then 0x104; one fp_we with fp_wr_reg=4, fp_fmt=5'h11, fp_wr_data=64'h3FF00000_00000000; done at cycle 4, err=0.
- Single store, reg 7 holding 0x7, addr 0x200 -> exactly one mem_req with mem_we=1, mem_addr=0x200, mem_wdata=0x7; no fp_we; done at cycle 3.
- Illegal cases: double load reg 5 (odd), double store addr 0x104, fmt 5'h14 -> each gives done=err=1 one cycle after accept; mem_req and fp_we never asserted.
- MEM_TIMEOUT=4, double load, mem_ack never asserted -> mem_req high exactly 4 cycles at 0x100; then done=err=1; no MEM_HI access, no fp_we.
- Double load with ack delayed 3 cycles on each word -> mem_addr and mem_req stable while waiting; data correct; done at cycle 10.
- rst_n low in MEM_HI of a double store -> all outputs 0 immediately, req_ready=1 after release; next single load to reg 2 completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP load/store definitions: format codes, sequencer states and the
// legality check, which the FP decode stage also uses.
package fp_pkg;

  localparam logic [4:0] FMT_S = 5'h10;
  localparam logic [4:0] FMT_D = 5'h11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDREG,
    ST_MEM_LO,
    ST_MEM_HI,
    ST_WRREG,
    ST_DONE
  } seq_state_t;

  // Singles need word alignment; doubles need an even register and doubleword alignment.
  function automatic logic ls_legal(input logic [4:0] fmt,
                                    input logic [4:0] fpreg,
                                    input logic [31:0] addr);
    logic ok;
    ok = 1'b0;
    if (fmt == FMT_S)
      ok = (addr[1:0] == 2'b00);
    else if (fmt == FMT_D)
      ok = !fpreg[0] && (addr[2:0] == 3'b000);
    return ok;
  endfunction

endpackage

// File: rtl/fp_mem_sequencer.sv
// Load/store sequencer between the FP memory stage and the 32-bit data port.
// Moves single words or even/odd register pairs between memory and the FP register file.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | ready for a request; legality checked on accept
//   ST_RDREG  | register file read of store source, captured at cycle end
//   ST_MEM_LO | low word access at addr, waiting for mem_ack or timeout
//   ST_MEM_HI | high word access at addr+4 (doubles only)
//   ST_WRREG  | one-cycle register file write of load result
//   ST_DONE   | one-cycle done pulse with err
module fp_mem_sequencer
  import fp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [4:0]  req_fmt,
  input  logic [4:0]  req_fpreg,
  input  logic [31:0] req_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  fp_fmt,
  output logic [4:0]  fp_rd_reg,
  input  logic [63:0] fp_rd_data,
  output logic        fp_we,
  output logic [4:0]  fp_wr_reg,
  output logic [63:0] fp_wr_data,
  output logic        done,
  output logic        err
);

  localparam bit              TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [TO_W:0]   TO_LIMIT = (TO_W + 1)'(MEM_TIMEOUT);

  seq_state_t       state;
  logic             cap_store;
  logic [4:0]       cap_fmt;
  logic [4:0]       cap_reg;
  logic [31:0]      cap_addr;
  logic [63:0]      data_buf;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W:0]    to_next;
  logic             to_hit;
  logic             cap_dbl;

  assign to_next = {1'b0, to_cnt} + {{TO_W{1'b0}}, 1'b1};
  assign to_hit  = TO_EN && (to_next == TO_LIMIT);
  assign cap_dbl = (cap_fmt == FMT_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fp_fmt     <= '0;
      fp_rd_reg  <= '0;
      fp_we      <= 1'b0;
      fp_wr_reg  <= '0;
      fp_wr_data <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cap_store  <= 1'b0;
      cap_fmt    <= '0;
      cap_reg    <= '0;
      cap_addr   <= '0;
      data_buf   <= '0;
      to_cnt     <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      fp_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            cap_store <= req_store;
            cap_fmt   <= req_fmt;
            cap_reg   <= req_fpreg;
            cap_addr  <= req_addr;
            fp_fmt    <= req_fmt;
            if (!ls_legal(req_fmt, req_fpreg, req_addr)) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (req_store) begin
              state     <= ST_RDREG;
              fp_rd_reg <= req_fpreg;
            end else begin
              state     <= ST_MEM_LO;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= req_addr;
              mem_wdata <= '0;
              to_cnt    <= '0;
            end
          end
        end

        // The register file presents read data by the negedge; take it straight to the port.
        ST_RDREG: begin
          data_buf  <= fp_rd_data;
          fp_rd_reg <= '0;
          state     <= ST_MEM_LO;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= cap_addr;
          mem_wdata <= fp_rd_data[31:0];
          to_cnt    <= '0;
        end

        ST_MEM_LO: begin
          if (mem_ack) begin
            if (!cap_store)
              data_buf[31:0] <= mem_rdata;
            if (cap_dbl) begin
              state     <= ST_MEM_HI;
              mem_addr  <= cap_addr + 32'd4;
              mem_wdata <= cap_store ? data_buf[63:32] : 32'h0;
              to_cnt    <= '0;
            end else begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              if (!cap_store) begin
                state      <= ST_WRREG;
                fp_we      <= 1'b1;
                fp_wr_reg  <= cap_reg;
                fp_wr_data <= {32'h0, mem_rdata};
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end else if (to_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= ST_DONE;
            done      <= 1'b1;
            err       <= 1'b1;
          end else begin
            to_cnt <= to_next[TO_W-1:0];
          end
        end

        ST_MEM_HI: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (!cap_store) begin
              data_buf[63:32] <= mem_rdata;
              state      <= ST_WRREG;
              fp_we      <= 1'b1;
              fp_wr_reg  <= cap_reg;
              fp_wr_data <= {mem_rdata, data_buf[31:0]};
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else if (to_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= ST_DONE;
            done      <= 1'b1;
            err       <= 1'b1;
          end else begin
            to_cnt <= to_next[TO_W-1:0];
          end
        end

        ST_WRREG: begin
          fp_wr_reg  <= '0;
          fp_wr_data <= '0;
          state      <= ST_DONE;
          done       <= 1'b1;
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          fp_fmt    <= '0;
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          fp_fmt    <= '0;
        end
      endcase
    end
  end

endmodule
